// File: rtl/sync_pulse_gen.sv
// Trigger-to-pulse generator: delayed, fixed-width registered level (e.g. HSYNC/VSYNC).
// Latency: busy_o rises one cycle after trig and pulse_o follows DELAY cycles later; no backpressure, and early triggers are flagged or restart the sequence.
module sync_pulse_gen #(
   parameter int CNT_W       = 10,
   parameter int DELAY       = 16,
   parameter int WIDTH       = 96,
   parameter bit ACTIVE_HIGH = 1'b0,
   parameter bit RETRIG      = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic trig,
   output logic pulse_o,
   output logic busy_o,
   output logic done_o,
   output logic overrun_o
);

   typedef enum logic [1:0] {S_IDLE, S_DELAY, S_ACTIVE} state_t;

   localparam logic [CNT_W-1:0] DLY_LD   = CNT_W'((DELAY > 0) ? DELAY - 1 : 0);
   localparam logic [CNT_W-1:0] WID_LD   = CNT_W'((WIDTH > 0) ? WIDTH - 1 : 0);
   localparam logic             PULSE_ON = ACTIVE_HIGH;

   state_t           state, state_nx;
   logic [CNT_W-1:0] count, count_nx;
   logic             busy, done_nx, ovr_nx;

   always_comb begin
      state_nx = state;
      count_nx = count;
      done_nx  = 1'b0;
      ovr_nx   = 1'b0;
      busy     = (state != S_IDLE);
      if (!en) begin
         state_nx = S_IDLE;
         count_nx = '0;
      end else if (trig && (!busy || RETRIG)) begin
         // Fresh start from IDLE, or a restart when retriggering is allowed.
         ovr_nx = busy;
         if (DELAY > 0) begin
            state_nx = S_DELAY;
            count_nx = DLY_LD;
         end else begin
            state_nx = S_ACTIVE;
            count_nx = WID_LD;
         end
      end else begin
         ovr_nx = trig && busy;
         case (state)
            S_DELAY: begin
               if (count == '0) begin
                  state_nx = S_ACTIVE;
                  count_nx = WID_LD;
               end else begin
                  count_nx = count - 1'b1;
               end
            end
            S_ACTIVE: begin
               if (count == '0) begin
                  state_nx = S_IDLE;
                  done_nx  = 1'b1;
               end else begin
                  count_nx = count - 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Outputs are flops loaded from the next state so the pad sees no glitches.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         count     <= '0;
         pulse_o   <= ~PULSE_ON;
         busy_o    <= 1'b0;
         done_o    <= 1'b0;
         overrun_o <= 1'b0;
      end else begin
         state     <= state_nx;
         count     <= count_nx;
         pulse_o   <= (state_nx == S_ACTIVE) ? PULSE_ON : ~PULSE_ON;
         busy_o    <= (state_nx != S_IDLE);
         done_o    <= done_nx;
         overrun_o <= ovr_nx;
      end
   end

endmodule

// File: tb/tb_sync_pulse_gen.sv
// Bench for sync_pulse_gen: three parameterisations share one stimulus stream and are
// checked every cycle against a trigger-time arithmetic model.
module tb_sync_pulse_gen;

   logic clk = 1'b0;
   logic rst_n, en, trig;
   logic p0, b0, d0, o0, p1, b1, d1, o1, p2, b2, d2, o2;
   logic [11:0] got;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   sync_pulse_gen u_dut (.clk(clk), .rst_n(rst_n), .en(en), .trig(trig),
      .pulse_o(p0), .busy_o(b0), .done_o(d0), .overrun_o(o0));

   sync_pulse_gen #(.DELAY(0), .WIDTH(1), .ACTIVE_HIGH(1'b1), .RETRIG(1'b0)) u_fast (
      .clk(clk), .rst_n(rst_n), .en(en), .trig(trig),
      .pulse_o(p1), .busy_o(b1), .done_o(d1), .overrun_o(o1));

   sync_pulse_gen #(.DELAY(16), .WIDTH(96), .RETRIG(1'b1)) u_rt (
      .clk(clk), .rst_n(rst_n), .en(en), .trig(trig),
      .pulse_o(p2), .busy_o(b2), .done_o(d2), .overrun_o(o2));

   assign got = {p0, b0, d0, o0, p1, b1, d1, o1, p2, b2, d2, o2};

   // Reference model: remember when each instance last accepted a trigger and derive
   // every output from the offset between that cycle and the current one.
   int cyc = 0;
   int st[3];
   bit act[3];
   bit e_ovr[3];

   function automatic int dly(input int i);
      return (i == 1) ? 0 : 16;
   endfunction
   function automatic int wid(input int i);
      return (i == 1) ? 1 : 96;
   endfunction
   function automatic bit ah(input int i);
      return (i == 1);
   endfunction
   function automatic bit rt(input int i);
      return (i == 2);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         act[i] = 1'b0;
         e_ovr[i] = 1'b0;
         st[i] = -1000;
      end
   endtask

   task automatic model_edge(input bit r, input bit e, input bit t);
      int k;
      bit bz;
      for (int i = 0; i < 3; i++) begin
         k = cyc - st[i];
         bz = act[i] && k >= 1 && k <= dly(i) + wid(i);
         if (!r || !e) begin
            act[i] = 1'b0;
            e_ovr[i] = 1'b0;
         end else if (t && (!bz || rt(i))) begin
            e_ovr[i] = bz;
            act[i] = 1'b1;
            st[i] = cyc;
         end else begin
            e_ovr[i] = t && bz;
         end
      end
      cyc++;
   endtask

   function automatic logic [3:0] exp_of(input int i);
      int k;
      bit bsy, pul, dn;
      k = cyc - st[i];
      bsy = act[i] && k >= 1 && k <= dly(i) + wid(i);
      pul = act[i] && k >= dly(i) + 1 && k <= dly(i) + wid(i);
      dn = act[i] && k == dly(i) + wid(i) + 1;
      return {pul ? ah(i) : ~ah(i), bsy, dn, e_ovr[i]};
   endfunction

   function automatic logic [11:0] exp_all();
      return {exp_of(0), exp_of(1), exp_of(2)};
   endfunction

   // One clock: inputs change just after the falling edge, outputs are read at the next one.
   task automatic drive(input bit e, input bit t);
      en = e;
      trig = t;
      @(posedge clk);
      model_edge(rst_n, e, t);
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; en = 1'b0; trig = 1'b0;
      model_reset();
      @(negedge clk);
      n_chk++;
      if (got !== 12'h808) begin
         n_fail++; $display("FAIL reset_values got=%h exp=%h", got, 12'h808);
      end
      rst_n = 1'b1;
      for (int k = 0; k < 5; k++) begin
         drive(1'b1, 1'b0);
         n_chk++;
         if (got !== exp_all()) begin
            n_fail++; $display("FAIL reset_idle cyc=%0d got=%h exp=%h", k, got, exp_all());
         end
      end
   endtask

   task automatic test_single();
      int done_at = -1, first_act = -1, n_act = 0, fast_done = -1;
      for (int k = 0; k < 120; k++) begin
         drive(1'b1, k == 0);
         n_chk++;
         if (got !== exp_all()) begin
            n_fail++; $display("FAIL single cyc=%0d got=%h exp=%h", k + 1, got, exp_all());
         end
         if (d0) done_at = k + 1;
         if (d1) fast_done = k + 1;
         if (!p0) begin
            n_act++;
            if (first_act < 0) first_act = k + 1;
         end
      end
      n_chk++;
      if (done_at != 113) begin
         n_fail++; $display("FAIL single_done got=%0d exp=113", done_at);
      end
      n_chk++;
      if (first_act != 17 || n_act != 96) begin
         n_fail++; $display("FAIL single_pulse first=%0d count=%0d exp 17/96", first_act, n_act);
      end
      n_chk++;
      if (fast_done != 2) begin
         n_fail++; $display("FAIL fast_done got=%0d exp=2", fast_done);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] mask = '0;
      for (int k = 0; k < 120; k++) begin
         drive(1'b1, k == 0 || k == 2);
         n_chk++;
         if (got !== exp_all()) begin
            n_fail++; $display("FAIL b2b cyc=%0d got=%h exp=%h", k + 1, got, exp_all());
         end
         if (k < 7) mask[k + 1] = p1;
      end
      n_chk++;
      if (mask !== 8'b0000_1010) begin
         n_fail++; $display("FAIL b2b_fast_pulse got=%b exp=%b", mask, 8'b0000_1010);
      end
   endtask

   task automatic test_overrun();
      int n_ovr = 0, ovr_at = -1, rt_done = -1, rt_first = -1;
      for (int k = 0; k < 170; k++) begin
         drive(1'b1, k == 0 || k == 50);
         n_chk++;
         if (got !== exp_all()) begin
            n_fail++; $display("FAIL overrun cyc=%0d got=%h exp=%h", k + 1, got, exp_all());
         end
         if (o0) begin n_ovr++; ovr_at = k + 1; end
         if (d2) rt_done = k + 1;
         if (!p2 && k + 1 > 51 && rt_first < 0) rt_first = k + 1;
      end
      n_chk++;
      if (n_ovr != 1 || ovr_at != 51) begin
         n_fail++; $display("FAIL overrun_strobe count=%0d at=%0d exp 1/51", n_ovr, ovr_at);
      end
      n_chk++;
      if (rt_done != 163 || rt_first != 67) begin
         n_fail++; $display("FAIL retrig_timing done=%0d first=%0d exp 163/67", rt_done, rt_first);
      end
   endtask

   task automatic test_enable();
      int n_done = 0, done_at = -1;
      logic busy41 = 1'b1;
      for (int k = 0; k < 180; k++) begin
         drive(!(k >= 40 && k < 60), k == 0 || k == 45 || k == 60);
         n_chk++;
         if (got !== exp_all()) begin
            n_fail++; $display("FAIL enable cyc=%0d got=%h exp=%h", k + 1, got, exp_all());
         end
         if (d0) begin n_done++; done_at = k + 1; end
         if (k + 1 == 41) busy41 = b0;
      end
      n_chk++;
      if (n_done != 1 || done_at != 173 || busy41 !== 1'b0) begin
         n_fail++; $display("FAIL enable_summary done=%0d at=%0d busy41=%b exp 1/173/0",
                            n_done, done_at, busy41);
      end
   endtask

   task automatic test_reset_mid();
      for (int k = 0; k < 30; k++) begin
         drive(1'b1, k == 0);
         n_chk++;
         if (got !== exp_all()) begin
            n_fail++; $display("FAIL rstmid_pre cyc=%0d got=%h exp=%h", k + 1, got, exp_all());
         end
      end
      rst_n = 1'b0;
      model_reset();
      #1;
      n_chk++;
      if (got !== 12'h808 || got !== exp_all()) begin
         n_fail++; $display("FAIL rstmid_async got=%h exp=%h", got, 12'h808);
      end
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         if (k == 2) rst_n = 1'b1;
         drive(1'b1, 1'b0);
         n_chk++;
         if (got !== exp_all()) begin
            n_fail++; $display("FAIL rstmid_post cyc=%0d got=%h exp=%h", k, got, exp_all());
         end
      end
      for (int k = 0; k < 100; k++) begin
         drive(1'b1, 1'b0);
         n_chk++;
         if (got !== 12'h808) begin
            n_fail++; $display("FAIL rstmid_idle cyc=%0d got=%h exp=%h", k, got, 12'h808);
         end
      end
   endtask

   task automatic test_random();
      int thr;
      for (int blk = 0; blk < 8; blk++) begin
         case (blk % 4)
            0: thr = 1;
            1: thr = 5;
            2: thr = 50;
            default: thr = 100;
         endcase
         for (int k = 0; k < 500; k++) begin
            drive($urandom_range(0, 31) != 0, $urandom_range(0, 99) < thr);
            n_chk++;
            if (got !== exp_all()) begin
               n_fail++; $display("FAIL random blk=%0d cyc=%0d got=%h exp=%h", blk, k, got, exp_all());
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_overrun();
      test_enable();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
